// File: rtl/hsync_pkg.sv
// Shared types, default timing and helper functions for the horizontal
// timing generator (hsync_timing_gen and its pixel replication counter).
package hsync_pkg;

  typedef enum logic [1:0] {
    PH_SYNC = 2'd0,
    PH_BP   = 2'd1,
    PH_ACT  = 2'd2,
    PH_FP   = 2'd3
  } phase_t;

  localparam int   DEF_SYNC_CYC     = 192;
  localparam int   DEF_BP_CYC       = 96;
  localparam int   DEF_PIX_PER_LINE = 128;
  localparam int   DEF_PIX_REP      = 10;
  localparam int   DEF_FP_CYC       = 32;
  localparam int   DEF_ADDR_W       = 7;
  localparam logic DEF_SYNC_POL     = 1'b0;

  // Width needed to count 0..n-1, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Largest of three lengths, used to size the shared phase counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/hsync_timing_gen_pix_rep_counter.sv
// Pixel replication counter for the active window of a line: holds each
// column address for PIX_REP clocks, then advances it, wrapping to zero after
// the last pixel. State is kept for the cycle currently being emitted; the
// advanced value is produced combinationally so the owner can look one clock
// ahead. With LEAD set, the address output is the look-ahead value.
module pix_rep_counter
  import hsync_pkg::*;
#(
  parameter int PIX_PER_LINE = DEF_PIX_PER_LINE,
  parameter int PIX_REP      = DEF_PIX_REP,
  parameter int PIX_W        = clog2_min1(DEF_PIX_PER_LINE),
  parameter int REP_W        = clog2_min1(DEF_PIX_REP),
  parameter bit LEAD         = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_step,
  input  logic             i_clear,
  input  logic             i_advance,
  output logic [PIX_W-1:0] o_addr_pix,
  output logic             o_last_pix
);

  localparam logic [REP_W-1:0] REP_LAST = REP_W'(PIX_REP - 1);
  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(PIX_PER_LINE - 1);

  logic [REP_W-1:0] r_rep;
  logic [PIX_W-1:0] r_pix;
  logic [REP_W-1:0] w_src_rep;
  logic [PIX_W-1:0] w_src_pix;
  logic [REP_W-1:0] w_adv_rep;
  logic [PIX_W-1:0] w_adv_pix;
  logic             w_rep_last;
  logic             w_pix_last;

  // A restart means "this cycle is the first of a line", so the counters are
  // treated as zero before advancing.
  assign w_src_rep  = i_clear ? '0 : r_rep;
  assign w_src_pix  = i_clear ? '0 : r_pix;
  assign w_rep_last = (w_src_rep == REP_LAST);
  assign w_pix_last = (w_src_pix == PIX_LAST);
  assign o_last_pix = w_rep_last & w_pix_last;
  assign o_addr_pix = LEAD ? w_adv_pix : w_src_pix;

  // Advance inside the active window; outside it the counters sit at zero so
  // the next window always starts at column 0, and the last column wraps to
  // zero instead of ever reaching PIX_PER_LINE.
  always_comb begin
    w_adv_rep = '0;
    w_adv_pix = '0;
    if (i_advance) begin
      if (w_rep_last) begin
        w_adv_rep = '0;
        w_adv_pix = w_pix_last ? '0 : (w_src_pix + PIX_W'(1));
      end else begin
        w_adv_rep = w_src_rep + REP_W'(1);
        w_adv_pix = w_src_pix;
      end
    end
  end

  // Counter registers only move on enabled or restarting clocks.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rep <= '0;
      r_pix <= '0;
    end else if (i_step) begin
      r_rep <= w_adv_rep;
      r_pix <= w_adv_pix;
    end
  end

endmodule

// File: rtl/hsync_timing_gen.sv
// Horizontal timing generator for the VGA driver. Sequences
// SYNC -> BACK PORCH -> ACTIVE -> FRONT PORCH each line and emits a registered
// HSYNC pin, a replicated VRAM column address with its read enable, the
// current phase and a line-end strobe for the vertical controller.
// Optional build macro HSYNC_TIMING_PREFETCH_EN: haddr/haddr_enable lead the
// active window by one clock to hide a one-cycle VRAM read latency.
//
// Internal state always describes the line cycle that the next enabled clock
// will present; on that clock the outputs are registered from it and the
// state steps forward. Reset therefore leaves state at "cycle 0 next".
module hsync_timing_gen
  import hsync_pkg::*;
#(
  parameter int   SYNC_CYC     = DEF_SYNC_CYC,
  parameter int   BP_CYC       = DEF_BP_CYC,
  parameter int   PIX_PER_LINE = DEF_PIX_PER_LINE,
  parameter int   PIX_REP      = DEF_PIX_REP,
  parameter int   FP_CYC       = DEF_FP_CYC,
  parameter int   ADDR_W       = DEF_ADDR_W,
  parameter logic SYNC_POL     = DEF_SYNC_POL
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              restart,
  output logic              hsync,
  output logic [ADDR_W-1:0] haddr,
  output logic              haddr_enable,
  output logic              line_end,
  output logic [1:0]        phase
);

  localparam int PCNT_W = clog2_min1(max3(SYNC_CYC, BP_CYC, FP_CYC));
  localparam int PIX_W  = clog2_min1(PIX_PER_LINE);
  localparam int REP_W  = clog2_min1(PIX_REP);

  localparam logic [PCNT_W-1:0] SYNC_LAST = PCNT_W'(SYNC_CYC - 1);
  localparam logic [PCNT_W-1:0] BP_LAST   = PCNT_W'(BP_CYC - 1);
  localparam logic [PCNT_W-1:0] FP_LAST   = PCNT_W'(FP_CYC - 1);

`ifdef HSYNC_TIMING_PREFETCH_EN
  localparam bit LEAD = 1'b1;
`else
  localparam bit LEAD = 1'b0;
`endif

  // Reject parameter sets the counters cannot represent.
  if (SYNC_CYC < 1 || BP_CYC < 1 || PIX_PER_LINE < 1 || PIX_REP < 1 ||
      FP_CYC < 1 || ADDR_W < 1 || PIX_PER_LINE > (2 ** ADDR_W)) begin : g_bad_params
    $error("hsync_timing_gen: illegal timing parameters");
  end

  phase_t              r_phase;
  logic [PCNT_W-1:0]   r_pcnt;
  phase_t              w_src_phase;
  logic [PCNT_W-1:0]   w_src_pcnt;
  phase_t              w_nxt_phase;
  logic [PCNT_W-1:0]   w_nxt_pcnt;
  logic                w_step;
  logic [PIX_W-1:0]    w_addr_pix;
  logic                w_last_pix;

  logic                w_hsync;
  logic [ADDR_W-1:0]   w_haddr;
  logic                w_haddr_enable;
  logic                w_line_end;

  logic                r_hsync;
  logic [ADDR_W-1:0]   r_haddr;
  logic                r_haddr_enable;
  logic                r_line_end;
  phase_t              r_phase_out;

  // Restart overrides both en and the natural wrap: present cycle 0 now.
  assign w_step      = en | restart;
  assign w_src_phase = restart ? PH_SYNC : r_phase;
  assign w_src_pcnt  = restart ? '0 : r_pcnt;

  pix_rep_counter #(
    .PIX_PER_LINE (PIX_PER_LINE),
    .PIX_REP      (PIX_REP),
    .PIX_W        (PIX_W),
    .REP_W        (REP_W),
    .LEAD         (LEAD)
  ) u_pix_rep_counter (
    .clk        (clk),
    .reset      (reset),
    .i_step     (w_step),
    .i_clear    (restart),
    .i_advance  (w_src_phase == PH_ACT),
    .o_addr_pix (w_addr_pix),
    .o_last_pix (w_last_pix)
  );

  // Phase state register: current phase and position within it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_phase <= PH_SYNC;
      r_pcnt  <= '0;
    end else if (w_step) begin
      r_phase <= w_nxt_phase;
      r_pcnt  <= w_nxt_pcnt;
    end
  end

  // Next phase: porches and sync count their own lengths, the active window
  // ends when the replication counter reports its final clock.
  always_comb begin
    w_nxt_phase = w_src_phase;
    w_nxt_pcnt  = w_src_pcnt + PCNT_W'(1);
    case (w_src_phase)
      PH_SYNC: begin
        if (w_src_pcnt == SYNC_LAST) begin
          w_nxt_phase = PH_BP;
          w_nxt_pcnt  = '0;
        end
      end
      PH_BP: begin
        if (w_src_pcnt == BP_LAST) begin
          w_nxt_phase = PH_ACT;
          w_nxt_pcnt  = '0;
        end
      end
      PH_ACT: begin
        w_nxt_pcnt = '0;
        if (w_last_pix) begin
          w_nxt_phase = PH_FP;
        end
      end
      PH_FP: begin
        if (w_src_pcnt == FP_LAST) begin
          w_nxt_phase = PH_SYNC;
          w_nxt_pcnt  = '0;
        end
      end
      default: begin
        w_nxt_phase = PH_SYNC;
        w_nxt_pcnt  = '0;
      end
    endcase
  end

  // Output decode for the cycle being presented; the prefetch build takes the
  // read enable from the following cycle so VRAM data lines up with ACTIVE.
  always_comb begin
    w_hsync    = (w_src_phase == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
    w_line_end = (w_src_phase == PH_FP) && (w_src_pcnt == FP_LAST);
    if (LEAD) begin
      w_haddr_enable = (w_nxt_phase == PH_ACT);
    end else begin
      w_haddr_enable = (w_src_phase == PH_ACT);
    end
    w_haddr = w_haddr_enable ? ADDR_W'(w_addr_pix) : '0;
  end

  // Output registers: hold everything, line_end included, while disabled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hsync        <= ~SYNC_POL;
      r_haddr        <= '0;
      r_haddr_enable <= 1'b0;
      r_line_end     <= 1'b0;
      r_phase_out    <= PH_SYNC;
    end else if (w_step) begin
      r_hsync        <= w_hsync;
      r_haddr        <= w_haddr;
      r_haddr_enable <= w_haddr_enable;
      r_line_end     <= w_line_end;
      r_phase_out    <= w_src_phase;
    end
  end

  assign hsync        = r_hsync;
  assign haddr        = r_haddr;
  assign haddr_enable = r_haddr_enable;
  assign line_end     = r_line_end;
  assign phase        = r_phase_out;

endmodule

// File: tb/tb_hsync_timing_gen.sv
// Scoreboard bench for hsync_timing_gen: one instance with default timing and
// one with a tiny line (SYNC=2, BP=1, PIX=4, REP=1, FP=1, ADDR_W=2).
// Driver pushes the expected outputs per clock; the monitor pops and compares.
module tb_hsync_timing_gen;
  import hsync_pkg::*;

`ifdef HSYNC_TIMING_PREFETCH_EN
  localparam int PF = 1;
`else
  localparam int PF = 0;
`endif

  typedef struct {
    int         id;
    int         t;
    logic       hs;
    logic       ae;
    logic [6:0] ad;
    logic       le;
    logic [1:0] ph;
  } exp_s;

  logic       clk = 1'b0;
  logic       reset;
  logic       en_a, restart_a, en_b, restart_b;
  logic       hsync_a, haddr_enable_a, line_end_a;
  logic [6:0] haddr_a;
  logic [1:0] phase_a;
  logic       hsync_b, haddr_enable_b, line_end_b;
  logic [1:0] haddr_b;
  logic [1:0] phase_b;

  exp_s sb[$];
  exp_s lastE[2];
  int   nextT[2];
  int   total = 0;
  int   bad   = 0;
  event sampleReq;

  always #5 clk = ~clk;

  hsync_timing_gen #(
    .SYNC_CYC(192), .BP_CYC(96), .PIX_PER_LINE(128), .PIX_REP(10),
    .FP_CYC(32), .ADDR_W(7), .SYNC_POL(1'b0)
  ) dutA (
    .clk(clk), .reset(reset), .en(en_a), .restart(restart_a),
    .hsync(hsync_a), .haddr(haddr_a), .haddr_enable(haddr_enable_a),
    .line_end(line_end_a), .phase(phase_a)
  );

  hsync_timing_gen #(
    .SYNC_CYC(2), .BP_CYC(1), .PIX_PER_LINE(4), .PIX_REP(1),
    .FP_CYC(1), .ADDR_W(2), .SYNC_POL(1'b0)
  ) dutB (
    .clk(clk), .reset(reset), .en(en_b), .restart(restart_b),
    .hsync(hsync_b), .haddr(haddr_b), .haddr_enable(haddr_enable_b),
    .line_end(line_end_b), .phase(phase_b)
  );

  function automatic int lineLen(int id);
    return (id == 0) ? 1600 : 8;
  endfunction

  function automatic exp_s row(int t, logic hs, logic ae, int ad, logic le, logic [1:0] ph);
    exp_s e;
    e.id = 0; e.t = t; e.hs = hs; e.ae = ae; e.ad = 7'(ad); e.le = le; e.ph = ph;
    return e;
  endfunction

  function automatic exp_s resetE(int id);
    exp_s e;
    e.id = id; e.t = -1; e.hs = 1'b1; e.ae = 1'b0; e.ad = '0; e.le = 1'b0; e.ph = PH_SYNC;
    return e;
  endfunction

  // Expected outputs at line cycle t: hand-computed rows for the default
  // timing's boundary points, closed-form timing arithmetic elsewhere.
  function automatic exp_s model(int id, int t);
    exp_s e;
    int sy, bp, pix, rep, fp, act0, actc, lo;
    if (id == 0) begin
`ifdef HSYNC_TIMING_PREFETCH_EN
      case (t)
        0:    return row(t, 1'b0, 1'b0, 0,   1'b0, PH_SYNC);
        286:  return row(t, 1'b1, 1'b0, 0,   1'b0, PH_BP);
        287:  return row(t, 1'b1, 1'b1, 0,   1'b0, PH_BP);
        296:  return row(t, 1'b1, 1'b1, 0,   1'b0, PH_ACT);
        297:  return row(t, 1'b1, 1'b1, 1,   1'b0, PH_ACT);
        1566: return row(t, 1'b1, 1'b1, 127, 1'b0, PH_ACT);
        1567: return row(t, 1'b1, 1'b0, 0,   1'b0, PH_ACT);
        1599: return row(t, 1'b1, 1'b0, 0,   1'b1, PH_FP);
        default: ;
      endcase
`else
      case (t)
        0:    return row(t, 1'b0, 1'b0, 0,   1'b0, PH_SYNC);
        191:  return row(t, 1'b0, 1'b0, 0,   1'b0, PH_SYNC);
        192:  return row(t, 1'b1, 1'b0, 0,   1'b0, PH_BP);
        287:  return row(t, 1'b1, 1'b0, 0,   1'b0, PH_BP);
        288:  return row(t, 1'b1, 1'b1, 0,   1'b0, PH_ACT);
        297:  return row(t, 1'b1, 1'b1, 0,   1'b0, PH_ACT);
        298:  return row(t, 1'b1, 1'b1, 1,   1'b0, PH_ACT);
        1558: return row(t, 1'b1, 1'b1, 127, 1'b0, PH_ACT);
        1567: return row(t, 1'b1, 1'b1, 127, 1'b0, PH_ACT);
        1568: return row(t, 1'b1, 1'b0, 0,   1'b0, PH_FP);
        1599: return row(t, 1'b1, 1'b0, 0,   1'b1, PH_FP);
        default: ;
      endcase
`endif
      sy = 192; bp = 96; pix = 128; rep = 10; fp = 32;
    end else begin
      sy = 2; bp = 1; pix = 4; rep = 1; fp = 1;
    end
    act0 = sy + bp;
    actc = pix * rep;
    lo   = act0 - PF;
    e.id = id;
    e.t  = t;
    e.hs = (t < sy) ? 1'b0 : 1'b1;
    if (t < sy)               e.ph = PH_SYNC;
    else if (t < act0)        e.ph = PH_BP;
    else if (t < act0 + actc) e.ph = PH_ACT;
    else                      e.ph = PH_FP;
    e.ae = (t >= lo) && (t < lo + actc);
    e.ad = e.ae ? 7'((t + PF - act0) / rep) : 7'd0;
    e.le = (t == act0 + actc + fp - 1);
    return e;
  endfunction

  // One clock edge on DUT id with the given en/restart; pushes the expectation.
  task automatic applyStimulus(input int id, input bit e, input bit r);
    exp_s x;
    int   t;
    en_a      = (id == 0) ? e : 1'b0;
    restart_a = (id == 0) ? r : 1'b0;
    en_b      = (id == 1) ? e : 1'b0;
    restart_b = (id == 1) ? r : 1'b0;
    @(posedge clk);
    if (r) begin
      x = model(id, 0);
      nextT[id] = 1;
    end else if (e) begin
      t = nextT[id];
      x = model(id, t);
      nextT[id] = (t + 1) % lineLen(id);
    end else begin
      x = lastE[id];
    end
    lastE[id] = x;
    sb.push_back(x);
    #1;
  endtask

  task automatic runCycles(input int id, input int n);
    repeat (n) applyStimulus(id, 1'b1, 1'b0);
  endtask

  // Step with en=1 until the edge that presents line cycle target.
  task automatic runTo(input int id, input int target);
    int guard = 0;
    while (nextT[id] != target && guard < 2 * lineLen(id)) begin
      applyStimulus(id, 1'b1, 1'b0);
      guard++;
    end
    applyStimulus(id, 1'b1, 1'b0);
  endtask

  // Assert reset away from any edge and check both DUTs before the next edge.
  task automatic pulseReset();
    @(negedge clk);
    #2 reset = 1'b1;
    nextT[0] = 0; nextT[1] = 0;
    lastE[0] = resetE(0); lastE[1] = resetE(1);
    #1 sb.push_back(resetE(0)); ->sampleReq;
    #1 sb.push_back(resetE(1)); ->sampleReq;
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
  endtask

  task automatic cmp(input string name, input int t, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("[TB] FAIL %s t=%0d actual=%0d required=%0d", name, t, act, req);
    end
  endtask

  task automatic checkOutput(input exp_s e);
    if (e.id == 0) begin
      cmp("A.hsync", e.t, int'(hsync_a), int'(e.hs));
      cmp("A.haddr_enable", e.t, int'(haddr_enable_a), int'(e.ae));
      cmp("A.haddr", e.t, int'(haddr_a), int'(e.ad));
      cmp("A.line_end", e.t, int'(line_end_a), int'(e.le));
      cmp("A.phase", e.t, int'(phase_a), int'(e.ph));
    end else begin
      cmp("B.hsync", e.t, int'(hsync_b), int'(e.hs));
      cmp("B.haddr_enable", e.t, int'(haddr_enable_b), int'(e.ae));
      cmp("B.haddr", e.t, int'(haddr_b), int'(e.ad));
      cmp("B.line_end", e.t, int'(line_end_b), int'(e.le));
      cmp("B.phase", e.t, int'(phase_b), int'(e.ph));
    end
  endtask

  // Monitor: one expectation per falling edge or explicit sample request.
  initial begin
    exp_s e;
    forever begin
      @(negedge clk or sampleReq);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checkOutput(e);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset = 1'b1;
    en_a = 1'b0; restart_a = 1'b0; en_b = 1'b0; restart_b = 1'b0;
    nextT[0] = 0; nextT[1] = 0;
    lastE[0] = resetE(0); lastE[1] = resetE(1);
    repeat (2) @(posedge clk);
    #2 sb.push_back(resetE(0)); ->sampleReq;
    #1 sb.push_back(resetE(1)); ->sampleReq;
    #1 reset = 1'b0;

    $display("[TB] two full lines, default timing");
    runCycles(0, 3200);
    $display("[TB] en low for 5 clocks at t=300");
    runTo(0, 300);
    repeat (5) applyStimulus(0, 1'b0, 1'b0);
    $display("[TB] restart at t=700, then restart with en=0");
    runTo(0, 700);
    applyStimulus(0, 1'b1, 1'b1);
    runCycles(0, 20);
    applyStimulus(0, 1'b0, 1'b1);
    repeat (3) applyStimulus(0, 1'b0, 1'b0);
    $display("[TB] async reset at t=1000");
    runTo(0, 1000);
    pulseReset();
    runCycles(0, 300);
    $display("[TB] small timing, 2.5 lines");
    runCycles(1, 20);

    @(negedge clk);
    #1;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("[TB] FAIL drain: pending=%0d required=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
